// File: rtl/watch_pkg.sv
// Shared timing defaults and button FSM state type for the watch control blocks.
package watch_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;   // 20 ms
    localparam int DEF_LONG_CYCLES     = CLK_HZ;        // 1 s
    localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;    // 200 ms

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Counter width for a count that runs 0 .. limit-1; never narrower than 1 bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// Raw pin synchronizer, optional polarity inversion and debounce counter.
// o_rise / o_fall flag the edge on which the debounced level is about to flip,
// so the parent can register its pulses into the first cycle of the new level.
module button_sync_debounce
    import watch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            INV     = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_level;
    logic                   w_sample;
    logic                   w_toggle;

    assign w_sample = r_sync[SYNC_STAGES-1] ^ INV;
    assign w_toggle = (w_sample != r_level) && (r_cnt == DB_LAST);
    assign o_level  = r_level;
    assign o_rise   = w_toggle & ~r_level;
    assign o_fall   = w_toggle &  r_level;

    // Synchronizer chain; reset loads the idle pin level so an active-low
    // button does not look pressed while the chain refills.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= {SYNC_STAGES{INV}};
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end

    // Count consecutive disagreeing samples; flip the level after a full stable run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_sample == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == DB_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Push-button event generator: debounced level plus single-cycle press,
// release, click, long-press and auto-repeat pulses.
module button_event_gen
    import watch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic Clk_50MHz,
    input  logic Reset,
    input  logic Button_Rw,
    output logic Level,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic ClickPulse,
    output logic LongPulse,
    output logic RepeatPulse
);

    localparam int                HOLD_W    = cnt_width(LONG_CYCLES);
    localparam int                REP_W     = cnt_width(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              w_rise;
    logic              w_fall;
    btn_state_t        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [REP_W-1:0]  r_rep;
    logic              r_press, r_release, r_click, r_long, r_repeat;

    button_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_sync_debounce (
        .i_clk   (Clk_50MHz),
        .i_rst   (Reset),
        .i_raw   (Button_Rw),
        .o_level (Level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign PressPulse   = r_press;
    assign ReleasePulse = r_release;
    assign ClickPulse   = r_click;
    assign LongPulse    = r_long;
    assign RepeatPulse  = r_repeat;

    // Hold-tracking FSM; a release on the same edge as a long/repeat threshold
    // takes priority so the interrupted event is dropped.
    always_ff @(posedge Clk_50MHz) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_rep     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HELD;
                        r_hold  <= '0;
                    end
                end
                HELD: begin
                    if (w_fall) begin
                        r_click <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_hold == HOLD_LAST) begin
                        r_long  <= 1'b1;
                        r_state <= REPEAT;
                        r_rep   <= '0;
                    end else begin
                        r_hold  <= r_hold + HOLD_W'(1);
                    end
                end
                REPEAT: begin
                    if (w_fall) begin
                        r_state  <= IDLE;
                    end else if (r_rep == REP_LAST) begin
                        r_repeat <= 1'b1;
                        r_rep    <= '0;
                    end else begin
                        r_rep    <= r_rep + REP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
